icache: RTL and testbench

Direct-mapped instruction cache answering the fetch unit's one-outstanding-request protocol. It returns a 32-bit instruction for a PC: one cycle after a hit, or after a single-word memory-controller read on a miss. It sits between instruction fetch and the memory controller's instruction port, and honours ROB misprediction flushes by suppressing stale responses.

---
 rtl/icache_pkg.sv | 17 +
 rtl/icache_array.sv | 48 ++++
 rtl/icache.sv | 130 +++++++++++++
 tb/tb_icache.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared header for the instruction cache: datapath widths, FSM encodings
// and a small address helper used by the top level.
package icache_pkg;

  localparam int REG_DAT_W = 32;
  localparam int INS_DAT_W = 32;

  // FSM encodings kept as plain constants so older code can compare them.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MISS = 1'b1;

  // Word-align a fetch PC for the memory controller.
  function automatic logic [REG_DAT_W-1:0] word_addr(input logic [REG_DAT_W-1:0] pc);
    return {pc[REG_DAT_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_array.sv
// Storage for the direct-mapped cache: one valid bit, tag and data word per
// line. Reads are combinational; a single write port updates on the edge.
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_W = 8,
  parameter int TAG_W   = REG_DAT_W - INDEX_W - 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INDEX_W-1:0]   rd_idx_i,
  output logic                 rd_valid_o,
  output logic [TAG_W-1:0]     rd_tag_o,
  output logic [INS_DAT_W-1:0] rd_data_o,
  input  logic                 wr_en_i,
  input  logic [INDEX_W-1:0]   wr_idx_i,
  input  logic [TAG_W-1:0]     wr_tag_i,
  input  logic [INS_DAT_W-1:0] wr_data_i
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]     valid_q;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [INS_DAT_W-1:0] data_q [LINES];

  // Valid bits are the only state that needs clearing; tags/data are don't-care until valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data storage, written alongside the valid bit.
  always_ff @(posedge clk) begin
    if (wr_en_i && !rst) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache between fetch and the memory controller.
// Fetch handshake: iIF_En is a one-cycle request sampled at a posedge; the
// answer is a one-cycle oIF_En pulse. Memory handshake: oMC_En is a level
// held with a stable oMC_Addr until the one-cycle iMC_En data strobe.
// A misprediction (iROB_Mp) suppresses any response due on the next cycle
// and marks an in-flight miss as stale; the fill itself still lands.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iIF_En,
  input  logic [REG_DAT_W-1:0] iIF_Pc,
  output logic                 oIF_En,
  output logic [INS_DAT_W-1:0] oIF_Ins,
  output logic                 oMC_En,
  output logic [REG_DAT_W-1:0] oMC_Addr,
  input  logic                 iMC_En,
  input  logic [INS_DAT_W-1:0] iMC_Dat,
  input  logic                 iROB_Mp
);

  localparam int TAG_W = REG_DAT_W - INDEX_W - 2;

  logic [0:0]           state_q, state_d;
  logic [REG_DAT_W-1:2] pc_q, pc_d;
  logic                 discard_q, discard_d;
  logic                 if_en_q, if_en_d;
  logic [INS_DAT_W-1:0] if_ins_q, if_ins_d;
  logic                 mc_en_q, mc_en_d;
  logic [REG_DAT_W-1:0] mc_addr_q, mc_addr_d;

  logic                 rd_valid;
  logic [TAG_W-1:0]     rd_tag;
  logic [INS_DAT_W-1:0] rd_data;
  logic                 wr_en;
  logic                 hit;

  // PC byte offset is irrelevant for word fetches.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^iIF_Pc[1:0];

  icache_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (iIF_Pc[INDEX_W+1:2]),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (wr_en),
    .wr_idx_i   (pc_q[INDEX_W+1:2]),
    .wr_tag_i   (pc_q[REG_DAT_W-1:INDEX_W+2]),
    .wr_data_i  (iMC_Dat)
  );

  assign hit = rd_valid && (rd_tag == iIF_Pc[REG_DAT_W-1:INDEX_W+2]);

  // Next-state logic for the IDLE/MISS controller and its output registers.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    if_en_d   = 1'b0;
    if_ins_d  = if_ins_q;
    mc_en_d   = mc_en_q;
    mc_addr_d = mc_addr_q;
    wr_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iIF_En && !iROB_Mp) begin
          if (hit) begin
            if_en_d  = 1'b1;
            if_ins_d = rd_data;
          end else begin
            pc_d      = iIF_Pc[REG_DAT_W-1:2];
            mc_en_d   = 1'b1;
            mc_addr_d = word_addr(iIF_Pc);
            discard_d = 1'b0;
            state_d   = ST_MISS;
          end
        end
      end
      default: begin
        // Requests arriving here violate the protocol and are ignored.
        if (iROB_Mp) discard_d = 1'b1;
        if (iMC_En) begin
          wr_en   = 1'b1;
          mc_en_d = 1'b0;
          state_d = ST_IDLE;
          if (!discard_q && !iROB_Mp) begin
            if_en_d  = 1'b1;
            if_ins_d = iMC_Dat;
          end
        end
      end
    endcase
  end

  // Register update; reset abandons any in-flight miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      discard_q <= 1'b0;
      if_en_q   <= 1'b0;
      if_ins_q  <= '0;
      mc_en_q   <= 1'b0;
      mc_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      if_en_q   <= if_en_d;
      if_ins_q  <= if_ins_d;
      mc_en_q   <= mc_en_d;
      mc_addr_q <= mc_addr_d;
    end
  end

  assign oIF_En   = if_en_q;
  assign oIF_Ins  = if_ins_q;
  assign oMC_En   = mc_en_q;
  assign oMC_Addr = mc_addr_q;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache. Inputs change on the falling edge and
// outputs are sampled on the falling edge, midway between active edges.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iIF_En = 1'b0;
  logic [31:0] iIF_Pc = '0;
  logic        oIF_En;
  logic [31:0] oIF_Ins;
  logic        oMC_En;
  logic [31:0] oMC_Addr;
  logic        iMC_En = 1'b0;
  logic [31:0] iMC_Dat = '0;
  logic        iROB_Mp = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];       // expected instructions on oIF_En
  logic [31:0] exp_addr_q[$];  // expected oMC_Addr on each oMC_En rise
  logic        mc_prev = 1'b0;

  icache #(.INDEX_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .iIF_En   (iIF_En),
    .iIF_Pc   (iIF_Pc),
    .oIF_En   (oIF_En),
    .oIF_Ins  (oIF_Ins),
    .oMC_En   (oMC_En),
    .oMC_Addr (oMC_Addr),
    .iMC_En   (iMC_En),
    .iMC_Dat  (iMC_Dat),
    .iROB_Mp  (iROB_Mp)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every response and every memory request is matched against the queues.
  always @(negedge clk) begin
    if (oIF_En === 1'b1) begin
      if (exp_q.size() == 0) check_eq("unexpected_resp", oIF_Ins, 32'hxxxx_xxxx);
      else check_eq("resp_data", oIF_Ins, exp_q.pop_front());
    end
    if (oMC_En === 1'b1 && !mc_prev) begin
      if (exp_addr_q.size() == 0) check_eq("unexpected_mc_req", oMC_Addr, 32'hxxxx_xxxx);
      else check_eq("mc_addr", oMC_Addr, exp_addr_q.pop_front());
    end
    mc_prev <= (oMC_En === 1'b1);
  end

  // Driver tasks; all are entered and left on a falling edge.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_req(input logic [31:0] pc, input logic mp);
    iIF_En  = 1'b1;
    iIF_Pc  = pc;
    iROB_Mp = mp;
    @(negedge clk);
    iIF_En  = 1'b0;
    iROB_Mp = 1'b0;
  endtask

  task automatic hit_req(input logic [31:0] pc, input logic [31:0] data);
    exp_q.push_back(data);
    do_req(pc, 1'b0);
    check_eq("hit_strobe", {31'd0, oIF_En}, 32'd1);
    check_eq("hit_no_mc", {31'd0, oMC_En}, 32'd0);
    @(negedge clk);
    check_eq("hit_pulse_single", {31'd0, oIF_En}, 32'd0);
  endtask

  task automatic miss_req(input logic [31:0] pc);
    exp_addr_q.push_back({pc[31:2], 2'b00});
    do_req(pc, 1'b0);
    check_eq("miss_no_resp", {31'd0, oIF_En}, 32'd0);
    check_eq("miss_mc_en", {31'd0, oMC_En}, 32'd1);
  endtask

  task automatic fill(input logic [31:0] data, input int delay, input logic mp, input logic resp);
    repeat (delay) begin
      @(negedge clk);
      check_eq("mc_hold", {31'd0, oMC_En}, 32'd1);
    end
    iMC_En  = 1'b1;
    iMC_Dat = data;
    iROB_Mp = mp;
    if (resp) exp_q.push_back(data);
    @(negedge clk);
    iMC_En  = 1'b0;
    iROB_Mp = 1'b0;
    check_eq("fill_resp", {31'd0, oIF_En}, {31'd0, resp});
    check_eq("fill_mc_drop", {31'd0, oMC_En}, 32'd0);
    @(negedge clk);
    check_eq("fill_pulse_single", {31'd0, oIF_En}, 32'd0);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check_eq("rst_if_en", {31'd0, oIF_En}, 32'd0);
    check_eq("rst_if_ins", oIF_Ins, 32'd0);
    check_eq("rst_mc_en", {31'd0, oMC_En}, 32'd0);
    check_eq("rst_mc_addr", oMC_Addr, 32'd0);

    // 1: cold miss, memory answers after 3 cycles
    miss_req(32'h0000_0004);
    check_eq("t1_mc_addr", oMC_Addr, 32'h0000_0004);
    fill(32'h0040_0093, 3, 1'b0, 1'b1);

    // 2: repeat hits
    hit_req(32'h0000_0004, 32'h0040_0093);

    // 3: conflict on the same index
    miss_req(32'h0000_0404);
    check_eq("t3_mc_addr", oMC_Addr, 32'h0000_0404);
    fill(32'h1111_2222, 2, 1'b0, 1'b1);
    hit_req(32'h0000_0404, 32'h1111_2222);
    miss_req(32'h0000_0004);
    fill(32'h0040_0093, 1, 1'b0, 1'b1);

    // 4: misprediction one cycle after oMC_En rises
    miss_req(32'h0000_0100);
    iROB_Mp = 1'b1;
    @(negedge clk);
    iROB_Mp = 1'b0;
    check_eq("t4_mc_held", {31'd0, oMC_En}, 32'd1);
    fill(32'hDEAD_BEEF, 2, 1'b0, 1'b0);
    hit_req(32'h0000_0100, 32'hDEAD_BEEF);

    // 5a: misprediction coincident with a hit request
    do_req(32'h0000_0100, 1'b1);
    check_eq("t5a_no_resp", {31'd0, oIF_En}, 32'd0);
    check_eq("t5a_no_mc", {31'd0, oMC_En}, 32'd0);
    @(negedge clk);
    // 5b: misprediction coincident with the fill strobe
    miss_req(32'h0000_0200);
    fill(32'hCAFE_F00D, 2, 1'b1, 1'b0);
    hit_req(32'h0000_0200, 32'hCAFE_F00D);

    // 6: reset mid-miss, then a stray memory strobe
    miss_req(32'h0000_0300);
    @(negedge clk);
    do_reset();
    check_eq("t6_mc_en", {31'd0, oMC_En}, 32'd0);
    check_eq("t6_mc_addr", oMC_Addr, 32'd0);
    iMC_En  = 1'b1;
    iMC_Dat = 32'h5555_AAAA;
    @(negedge clk);
    iMC_En  = 1'b0;
    check_eq("t6_stray_no_resp", {31'd0, oIF_En}, 32'd0);
    check_eq("t6_stray_no_mc", {31'd0, oMC_En}, 32'd0);
    miss_req(32'h0000_0300);
    fill(32'h0000_0300, 1, 1'b0, 1'b1);
    miss_req(32'h0000_0004);
    fill(32'h0040_0093, 1, 1'b0, 1'b1);
    miss_req(32'h0000_0100);
    fill(32'h0000_0013, 1, 1'b0, 1'b1);

    // A few random refetches of resident lines
    for (int i = 0; i < 6; i++) begin
      case ($urandom_range(0, 2))
        0:       hit_req(32'h0000_0300, 32'h0000_0300);
        1:       hit_req(32'h0000_0004, 32'h0040_0093);
        default: hit_req(32'h0000_0100, 32'h0000_0013);
      endcase
    end

    repeat (2) @(negedge clk);
    check_eq("resp_q_drained", exp_q.size(), 32'd0);
    check_eq("addr_q_drained", exp_addr_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
